// File: rtl/pipelined_kogge_stone_addsub_if.sv
// Purpose: operand/result bundle for the pipelined Kogge-Stone adder/subtractor.
// Latency: none; wires only.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface pipelined_kogge_stone_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  // Producer/consumer side of the block.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  // The adder itself.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_kogge_stone_addsub.sv
// Purpose: WIDTH-bit add/subtract with carry/borrow-in and cout/ovf/zero flags, Kogge-Stone prefix tree.
// Latency: LOG2W+2 cycles (input stage, one register per prefix level, output stage); 1 op/cycle.
// Backpressure: one global enable (~out_valid | out_ready) freezes every stage; in_ready equals that enable.
module pipelined_kogge_stone_addsub #(
  parameter int WIDTH = 16,
  parameter int LOG2W = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  pipelined_kogge_stone_addsub_if.slave bus
);

  if (((1 << LOG2W) != WIDTH) || (LOG2W < 2) || (LOG2W > 6)) begin : g_bad_param
    $error("pipelined_kogge_stone_addsub: WIDTH must be 2**LOG2W with WIDTH in 4..64");
  end

  // Prefix positions run 0..WIDTH: position 0 carries c0 as a pure generate
  // (p=0), position k+1 holds bit k. Index 0 of each array is the input stage,
  // index l is the result of prefix level l (span 2**(l-1)).
  logic             en;
  logic [WIDTH:0]   g_q  [LOG2W+1];
  logic [WIDTH:0]   p_q  [LOG2W+1];
  logic [WIDTH:0]   g_d  [LOG2W+1];
  logic [WIDTH:0]   p_d  [LOG2W+1];
  logic [WIDTH-1:0] hs_q [LOG2W+1];
  logic [WIDTH-1:0] hs_d [LOG2W+1];
  logic [LOG2W:0]   vld_q;
  logic [LOG2W:0]   vld_d;

  logic [WIDTH-1:0] bx;
  logic             c0;

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             zero_d;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             out_vld_q;

  // Only the top bit of the last level's propagate feeds the carry-out fold.
  logic             unused_p;
  assign unused_p = ^p_q[LOG2W][WIDTH-1:0];

  assign en           = ~out_vld_q | bus.out_ready;
  assign bus.in_ready = en;

  // Input stage: conditional inversion of b for subtract and per-bit generate/propagate.
  always_comb begin
    bx       = bus.b ^ {WIDTH{bus.sub}};
    c0       = bus.cin ^ bus.sub;
    g_d[0]   = {bus.a & bx, c0};
    p_d[0]   = {bus.a ^ bx, 1'b0};
    hs_d[0]  = bus.a ^ bx;
  end

  // Prefix levels: each position combines with the one 'span' below it;
  // positions below span have no partner and pass through unchanged
  // (shifted-in zeros for g and ones for p make the operator an identity).
  for (genvar l = 1; l <= LOG2W; l++) begin : g_level
    localparam int SPAN = 1 << (l - 1);
    assign g_d[l]  = g_q[l-1] | (p_q[l-1] & {g_q[l-1][WIDTH-SPAN:0], {SPAN{1'b0}}});
    assign p_d[l]  = p_q[l-1] & {p_q[l-1][WIDTH-SPAN:0], {SPAN{1'b1}}};
    assign hs_d[l] = hs_q[l-1];
  end

  assign vld_d = {vld_q[LOG2W-1:0], bus.in_valid};

  // Output stage combinational: after LOG2W levels every position below WIDTH
  // already spans down to position 0, so its group generate is the carry into
  // that bit. Position WIDTH spans only 1..WIDTH and needs c0 folded in once more.
  always_comb begin
    carry  = g_q[LOG2W][WIDTH-1:0];
    sum_d  = hs_q[LOG2W] ^ carry;
    cout_d = g_q[LOG2W][WIDTH] | (p_q[LOG2W][WIDTH] & g_q[LOG2W][0]);
    ovf_d  = cout_d ^ carry[WIDTH-1];
    zero_d = ~|sum_d;
  end

  // Datapath stage registers: advance with the global enable, no reset needed.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int l = 0; l <= LOG2W; l++) begin
        g_q[l]  <= g_d[l];
        p_q[l]  <= p_d[l];
        hs_q[l] <= hs_d[l];
      end
    end
  end

  // Valid bits and output registers: cleared by reset; outputs only load from a
  // valid stage so stale or uninitialised datapath contents never appear.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q     <= '0;
      out_vld_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else if (en) begin
      vld_q     <= vld_d;
      out_vld_q <= vld_q[LOG2W];
      if (vld_q[LOG2W]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipelined_kogge_stone_addsub.sv
// Purpose: scoreboard bench for pipelined_kogge_stone_addsub at WIDTH=16 and WIDTH=32.
// Latency: checks 6/7-cycle latency where the consumer never stalls.
// Backpressure: drives out_ready low (directed stall, random) and checks hold behaviour.
module tb_pipelined_kogge_stone_addsub;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit rmode    = 1'b0;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          cyc;
    int          lat;   // 0: latency not checked
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];

  pipelined_kogge_stone_addsub_if #(.WIDTH(16)) b16 ();
  pipelined_kogge_stone_addsub_if #(.WIDTH(32)) b32 ();

  pipelined_kogge_stone_addsub #(.WIDTH(16), .LOG2W(4)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (b16)
  );

  pipelined_kogge_stone_addsub #(.WIDTH(32), .LOG2W(5)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (b32)
  );

  always @(posedge clk) cyc++;

  // Random consumer, active only while rmode is set.
  always @(posedge clk) begin
    #2;
    if (rmode) begin
      b16.out_ready = ($urandom_range(0, 3) != 0);
      b32.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_cmp(input string nm, input logic [63:0] s, input logic c, input logic o,
                        input logic z, input exp_t e);
    checks++;
    if (s !== e.sum || c !== e.cout || o !== e.ovf || z !== e.zero) begin
      failures++;
      $display("FAIL %s result: got sum=%0h cout=%b ovf=%b zero=%b want sum=%0h cout=%b ovf=%b zero=%b",
               nm, s, c, o, z, e.sum, e.cout, e.ovf, e.zero);
    end
    if (e.lat != 0) begin
      checks++;
      if (cyc - e.cyc != e.lat) begin
        failures++;
        $display("FAIL %s latency: got %0d want %0d", nm, cyc - e.cyc, e.lat);
      end
    end
  endtask

  // Monitors: one pop per result consumed on the following rising edge.
  always @(negedge clk) begin
    if (!reset && b16.out_valid && b16.out_ready) begin
      if (q16.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w16_unexpected: got sum=%0h want no output", b16.sum);
      end else begin
        do_cmp("w16", {48'd0, b16.sum}, b16.cout, b16.ovf, b16.zero, q16.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b32.out_valid && b32.out_ready) begin
      if (q32.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w32_unexpected: got sum=%0h want no output", b32.sum);
      end else begin
        do_cmp("w32", {32'd0, b32.sum}, b32.cout, b32.ovf, b32.zero, q32.pop_front());
      end
    end
  end

  task automatic model(input int w, input logic [63:0] a, input logic [63:0] b, input logic ci,
                       input logic sb, output logic [63:0] s, output logic co, output logic ov,
                       output logic z);
    logic [64:0] mask;
    logic [64:0] bx;
    logic [64:0] full;
    mask = (65'd1 << w) - 65'd1;
    bx   = ({1'b0, b} ^ (sb ? mask : 65'd0)) & mask;
    full = ({1'b0, a} & mask) + bx + {64'd0, ci ^ sb};
    s    = full[63:0] & mask[63:0];
    co   = full[w];
    ov   = (a[w-1] == bx[w-1]) && (s[w-1] != a[w-1]);
    z    = (s == 64'd0);
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb,
                         input logic [15:0] es, input logic ec, input logic eo, input logic ez,
                         input int lat);
    exp_t e;
    int   n;
    b16.in_valid = 1'b1;
    b16.a = a; b16.b = b; b16.cin = ci; b16.sub = sb;
    n = 0;
    while (!b16.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!b16.in_ready) begin
      checks++;
      failures++;
      $display("FAIL w16_accept_timeout: got in_ready=0 want 1");
    end else begin
      e.sum = {48'd0, es}; e.cout = ec; e.ovf = eo; e.zero = ez; e.cyc = cyc; e.lat = lat;
      q16.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb,
                         input logic [31:0] es, input logic ec, input logic eo, input logic ez,
                         input int lat);
    exp_t e;
    int   n;
    b32.in_valid = 1'b1;
    b32.a = a; b32.b = b; b32.cin = ci; b32.sub = sb;
    n = 0;
    while (!b32.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!b32.in_ready) begin
      checks++;
      failures++;
      $display("FAIL w32_accept_timeout: got in_ready=0 want 1");
    end else begin
      e.sum = {32'd0, es}; e.cout = ec; e.ovf = eo; e.zero = ez; e.cyc = cyc; e.lat = lat;
      q32.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic rnd16();
    logic [63:0] a, b, s;
    logic ci, sb, co, ov, z;
    a  = {48'd0, 16'($urandom)};
    b  = {48'd0, 16'($urandom)};
    if ($urandom_range(0, 15) == 0) b = 64'h0000_0000_0000_ffff;
    ci = 1'($urandom);
    sb = 1'($urandom);
    model(16, a, b, ci, sb, s, co, ov, z);
    issue16(a[15:0], b[15:0], ci, sb, s[15:0], co, ov, z, 0);
  endtask

  task automatic rnd32();
    logic [63:0] a, b, s;
    logic ci, sb, co, ov, z;
    a  = {32'd0, 32'($urandom)};
    b  = {32'd0, 32'($urandom)};
    if ($urandom_range(0, 15) == 0) a = 64'h0000_0000_ffff_ffff;
    ci = 1'($urandom);
    sb = 1'($urandom);
    model(32, a, b, ci, sb, s, co, ov, z);
    issue32(a[31:0], b[31:0], ci, sb, s[31:0], co, ov, z, 0);
  endtask

  task automatic idle16();
    b16.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_empty(input string nm);
    int n;
    n = 0;
    while ((q16.size() != 0 || q32.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(q16.size() + q32.size()), 64'd0);
  endtask

  // Hand-computed results for a=i*0x1111, b=0x0101, sub=i[0], cin=0.
  logic [15:0] str_sum  [10] = '{16'h0101, 16'h1010, 16'h2323, 16'h3232, 16'h4545,
                                 16'h5454, 16'h6767, 16'h7676, 16'h8989, 16'h9898};
  logic        str_cout [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0; b16.sub = 1'b0; b16.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.a = '0; b32.b = '0; b32.cin = 1'b0; b32.sub = 1'b0; b32.out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state, with the consumer not ready so in_ready reflects out_valid=0.
    b16.out_ready = 1'b0;
    chk("rst_out_valid", b16.out_valid, 1'b0);
    chk("rst_outputs", {b16.sum, b16.cout, b16.ovf, b16.zero}, 64'd0);
    chk("rst_in_ready", b16.in_ready, 1'b1);
    chk("rst_out_valid32", b32.out_valid, 1'b0);
    b16.out_ready = 1'b1;

    // Directed vectors.
    issue16(16'hffff, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 6);
    idle16();
    issue16(16'h7fff, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 6);
    issue16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hfffe, 1'b0, 1'b0, 1'b0, 6);
    issue16(16'h0007, 16'h0007, 1'b1, 1'b1, 16'hffff, 1'b0, 1'b0, 1'b0, 6);
    issue16(16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 6);
    issue16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7fff, 1'b1, 1'b1, 1'b0, 6);
    issue16(16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 6);
    issue16(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 6);
    idle16();
    issue32(32'hffff_ffff, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 7);
    issue32(32'h7fff_ffff, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 7);
    issue32(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hffff_fffe, 1'b0, 1'b0, 1'b0, 7);
    b32.in_valid = 1'b0;
    wait_empty("drain_directed");

    // Back-to-back stream with a three-cycle consumer stall.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int ib;
          ib = i;
          issue16(16'(i * 16'h1111), 16'h0101, 1'b0, ib[0], str_sum[i], str_cout[i], 1'b0, 1'b0, 0);
        end
        idle16();
      end
      begin
        repeat (8) @(posedge clk);
        #2 b16.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_out_valid", b16.out_valid, 1'b1);
          chk("stall_in_ready", b16.in_ready, 1'b0);
          if (q16.size() > 0) chk("stall_hold_sum", {48'd0, b16.sum}, q16[0].sum);
        end
        @(posedge clk);
        #2 b16.out_ready = 1'b1;
      end
    join
    wait_empty("drain_stream");

    // Alternating valid: every result must emerge exactly 6 cycles after issue.
    for (int k = 1; k <= 5; k++) begin
      issue16(16'(k * 16'h0011), 16'(k * 16'h0011), 1'b0, 1'b0, 16'(k * 16'h0022), 1'b0, 1'b0, 1'b0, 6);
      idle16();
    end
    wait_empty("drain_alternate");

    // Reset while four operations are in flight, with a fifth presented during reset.
    for (int k = 0; k < 4; k++) issue16(16'h0100, 16'h0001, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0, 6);
    b16.a = 16'h1234; b16.b = 16'h4321; b16.in_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    b16.in_valid = 1'b0;
    q16.delete();
    b16.out_ready = 1'b0;
    chk("post_rst_in_ready", b16.in_ready, 1'b1);
    b16.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("post_rst_out_valid", b16.out_valid, 1'b0);
      @(negedge clk);
    end
    issue16(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 6);
    idle16();
    wait_empty("drain_after_reset");

    // Random operands on both widths with a random consumer.
    rmode = 1'b1;
    fork
      begin
        for (int i = 0; i < 20000; i++) begin
          rnd16();
          if ($urandom_range(0, 7) == 0) idle16();
        end
        b16.in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 20000; i++) rnd32();
        b32.in_valid = 1'b0;
      end
    join
    rmode = 1'b0;
    @(posedge clk);
    #3;
    b16.out_ready = 1'b1;
    b32.out_ready = 1'b1;
    wait_empty("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got no end of test want end within 200000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipelined_kogge_stone_addsub.md
Name: pipelined_kogge_stone_addsub

Overview:
Parametrised, fully pipelined Kogge-Stone prefix adder/subtractor. It is the next generation of the 16-bit combinational Kogge-Stone adder, with:
- configurable width;
- add/subtract mode with borrow-in;
- status flags;
- one register per prefix level;
- valid/ready flow control.

It accepts one operation per cycle, and results leave in issue order. It sits in datapaths that need a wide adder closing timing at high clock rates.

Parameters:
WIDTH, 16, operand/sum width; power of two, 4..64.
LOG2W, 4, log2(WIDTH); number of prefix levels; must be consistent with WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operation presented on a/b/cin/sub.
in_ready  output  1  block accepts the operation this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add) / borrow-in (sub).
sub  input  1  0 = add, 1 = subtract.
out_valid  output  1  result present on sum/cout/ovf/zero.
out_ready  input  1  consumer takes the result this cycle.
sum  output  WIDTH  result.
cout  output  1  carry out of bit WIDTH-1.
ovf  output  1  two's-complement signed overflow.
zero  output  1  sum == 0.

Behaviour:
- Arithmetic:
  - bx = b XOR {WIDTH{sub}}; c0 = cin XOR sub.
  - {cout, sum} = a + bx + c0, computed modulo 2^(WIDTH+1).
  - sub=1, cin=0 gives a-b; sub=1, cin=1 gives a-b-1.
  - In subtract mode, cout=1 means no borrow.
- Flags:
  - ovf = carry into bit WIDTH XOR carry into bit WIDTH-1.
  - zero = ~|sum.
- Pipeline structure:
  - Stage 0 registers a, bx, c0, and the generate/propagate bits.
  - Stages 1..LOG2W each register one Kogge-Stone prefix level (span 1, 2, 4, ... WIDTH/2). The c0 term is folded in as a generate at position -1.
  - The final stage registers sum, cout, ovf and zero.
  - Latency = LOG2W+2 cycles from acceptance to out_valid; 6 cycles for WIDTH=16.
- Valid bits: each stage carries a valid bit that travels with its data.
- Flow control:
  - Global enable en = ~out_valid | out_ready; in_ready = en.
  - An operation is accepted when in_valid & in_ready.
  - When en=1, every stage shifts forward one cycle. A bubble (valid=0) enters when in_valid=0.
  - When en=0, all stages hold data and valid bits, and sum/cout/ovf/zero remain stable while out_valid=1.
  - A result is consumed when out_valid & out_ready. A new result can be consumed and a new operation accepted in the same cycle, giving a throughput of 1/cycle.
  - Inputs presented while in_ready=0 are ignored and must be re-presented by the producer.
- Reset:
  - The block samples reset on the clock edge.
  - All stage valid bits clear, out_valid=0, and sum/cout/ovf/zero=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-flight discards every in-flight operation; no partial result is ever emitted.
  - reset has priority over any simultaneous in_valid.
- Datapath registers other than the output registers need not be reset. No X may reach the outputs while out_valid=1.
- Ordering: results emerge strictly in acceptance order; none is dropped or duplicated.

Test Plan:
- WIDTH=16, add a=0xFFFF, b=0x0001, cin=0 -> after 6 cycles out_valid=1, sum=0x0000, cout=1, zero=1, ovf=0.
- Add a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1, zero=0. Sub a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Sub a=0x0007, b=0x0007, cin=1 -> sum=0xFFFF, cout=0.
- Stream 10 back-to-back ops (a=i*0x1111, b=0x0101, sub=i[0]) with out_ready held low for cycles 8..10 -> in_ready=0 during the stall, outputs held stable, all 10 results correct and in order, no duplicates.
- Accept 4 ops, assert reset for 1 cycle while they are in flight -> out_valid stays 0 for the next 8 cycles and in_ready=1 the cycle after reset. A new op after reset yields its correct result at latency 6.
- Alternate in_valid 1/0 with out_ready=1 -> out_valid shows the same 1/0 pattern delayed by 6 cycles.
- WIDTH=32 (LOG2W=5) and WIDTH=16: 20000 random a/b/cin/sub with random out_ready -> every result matches the reference model {cout,sum} = a + bx + c0 with correct ovf/zero, latency 7 and 6 respectively when unstalled; zero mismatches.
